ring_slot_decoder: RTL and testbench

- Receive-side companion to the 15-bit stride-3 ring counter.
- Samples the ring vector, validates it, and decodes it to a binary slot index (0-4).
- Emits per-step and per-lap pulses and judges player button presses against a target slot.
- Sits between the ring counter and the scoring/display logic; counts laps and latches protocol errors.

---
 rtl/ring_slot_decoder.sv | 142 ++++++++++++++
 tb/tb_ring_slot_decoder.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_slot_decoder.sv
// Decodes a stride-spaced one-hot ring vector to a slot index, tracks
// step/lap progress, judges button presses and latches protocol errors.
module ring_slot_decoder #(
    parameter int WIDTH  = 15,
    parameter int STRIDE = 3,
    parameter int SLOTS  = 5,
    parameter int LAP_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] ring_in,
    input  logic [2:0]       tgt_slot,
    input  logic             hit_btn,
    input  logic             err_clr,
    output logic [2:0]       pos_idx,
    output logic             pos_valid,
    output logic             step,
    output logic             lap_pulse,
    output logic [LAP_W-1:0] lap_cnt,
    output logic             hit,
    output logic             miss,
    output logic             err_sticky
);

    typedef enum logic {
        UNSYNCED = 1'b0,
        SYNCED   = 1'b1
    } state_e;

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [2:0]       LAST    = 3'(SLOTS - 1);
    localparam logic [2:0]       NSLOTS  = 3'(SLOTS);
    localparam logic [LAP_W-1:0] LAP_MAX = '1;

    state_e           state_q, state_d;
    logic [2:0]       pos_q, pos_d;
    logic             valid_q, valid_d;
    logic             step_q, step_d;
    logic             lap_q, lap_d;
    logic [LAP_W-1:0] cnt_q, cnt_d;
    logic             hit_q, hit_d;
    logic             miss_q, miss_d;
    logic             err_q, err_d;

    logic       legal;
    logic [2:0] k_idx;
    logic [2:0] pos_inc;
    logic       set_err;

    always_comb begin
        legal = 1'b0;
        k_idx = '0;
        for (int k = 0; k < SLOTS; k++) begin
            if (ring_in == (ONE << (k * STRIDE))) begin
                legal = 1'b1;
                k_idx = 3'(k);
            end
        end
    end

    // Successor wraps at SLOTS, not at the 3-bit boundary
    assign pos_inc = (pos_q == LAST) ? 3'd0 : pos_q + 3'd1;

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        valid_d = valid_q;
        step_d  = 1'b0;
        lap_d   = 1'b0;
        cnt_d   = cnt_q;
        set_err = 1'b0;
        if (en) begin
            if (!legal) begin
                valid_d = 1'b0;
                set_err = 1'b1;
                state_d = UNSYNCED;
            end else begin
                unique case (state_q)
                    UNSYNCED: begin
                        pos_d   = k_idx;
                        valid_d = 1'b1;
                        state_d = SYNCED;
                    end
                    SYNCED: begin
                        if (k_idx == pos_inc) begin
                            pos_d  = k_idx;
                            step_d = 1'b1;
                            if (k_idx == 3'd0) begin
                                lap_d = 1'b1;
                                if (cnt_q != LAP_MAX)
                                    cnt_d = cnt_q + 1'b1;
                            end
                        end else if (k_idx != pos_q) begin
                            pos_d   = k_idx;
                            set_err = 1'b1;
                        end
                    end
                    default: state_d = UNSYNCED;
                endcase
            end
        end
        hit_d  = hit_btn && valid_q && (tgt_slot < NSLOTS)
                 && (pos_q == tgt_slot);
        miss_d = hit_btn && !hit_d;
        err_d  = set_err | (err_q & ~err_clr);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= UNSYNCED;
            pos_q   <= '0;
            valid_q <= 1'b0;
            step_q  <= 1'b0;
            lap_q   <= 1'b0;
            cnt_q   <= '0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            valid_q <= valid_d;
            step_q  <= step_d;
            lap_q   <= lap_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            err_q   <= err_d;
        end
    end

    assign pos_idx    = pos_q;
    assign pos_valid  = valid_q;
    assign step       = step_q;
    assign lap_pulse  = lap_q;
    assign lap_cnt    = cnt_q;
    assign hit        = hit_q;
    assign miss       = miss_q;
    assign err_sticky = err_q;

endmodule

// File: tb/tb_ring_slot_decoder.sv
// Bench for ring_slot_decoder: directed scenarios plus random traffic
// against a slot-level reference model (LAP_W=2 to reach saturation).
module tb_ring_slot_decoder;

    localparam int WIDTH = 15;
    localparam int LAP_W = 2;
    localparam int OW    = 3 + 5 + LAP_W + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic [WIDTH-1:0] ring_in;
    logic [2:0]       tgt_slot;
    logic             hit_btn;
    logic             err_clr;
    logic [2:0]       pos_idx;
    logic             pos_valid;
    logic             step;
    logic             lap_pulse;
    logic [LAP_W-1:0] lap_cnt;
    logic             hit;
    logic             miss;
    logic             err_sticky;

    int vectors = 0;
    int miscompares = 0;

    int m_pos, m_cnt;
    bit m_valid, m_step, m_lap, m_hit, m_miss, m_err;

    ring_slot_decoder #(.LAP_W(LAP_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .ring_in(ring_in),
        .tgt_slot(tgt_slot), .hit_btn(hit_btn), .err_clr(err_clr),
        .pos_idx(pos_idx), .pos_valid(pos_valid), .step(step),
        .lap_pulse(lap_pulse), .lap_cnt(lap_cnt), .hit(hit),
        .miss(miss), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    function automatic logic [OW-1:0] obs();
        return {pos_idx, pos_valid, step, lap_pulse, hit, miss,
                lap_cnt, err_sticky};
    endfunction

    function automatic logic [OW-1:0] expv();
        return {3'(m_pos), m_valid, m_step, m_lap, m_hit, m_miss,
                LAP_W'(m_cnt), m_err};
    endfunction

    // Slot number of a sample, or -1 when the vector is not a legal position
    function automatic int slot_of(logic [WIDTH-1:0] v);
        if ($countones(v) != 1) return -1;
        for (int b = 0; b < WIDTH; b++)
            if (v[b]) return (b % 3 == 0 && b < 15) ? b / 3 : -1;
        return -1;
    endfunction

    function automatic logic [WIDTH-1:0] slot_vec(int s);
        logic [WIDTH-1:0] v;
        v = '0;
        v[s * 3] = 1'b1;
        return v;
    endfunction

    task automatic cycle(bit r, bit e, logic [WIDTH-1:0] ring,
                         int tgt, bit btn, bit clr);
        int k;
        bit serr;
        rst_n = r; en = e; ring_in = ring;
        tgt_slot = 3'(tgt); hit_btn = btn; err_clr = clr;
        @(posedge clk);
        if (!r) begin
            m_pos = 0; m_valid = 0; m_step = 0; m_lap = 0;
            m_cnt = 0; m_hit = 0; m_miss = 0; m_err = 0;
        end else begin
            m_hit  = btn && m_valid && tgt < 5 && m_pos == tgt;
            m_miss = btn && !m_hit;
            m_step = 0; m_lap = 0; serr = 0;
            if (e) begin
                k = slot_of(ring);
                if (k < 0) begin
                    m_valid = 0; serr = 1;
                end else if (!m_valid) begin
                    m_pos = k; m_valid = 1;
                end else if (k == (m_pos + 1) % 5) begin
                    m_pos = k; m_step = 1;
                    if (k == 0) begin
                        m_lap = 1;
                        m_cnt = (m_cnt < 3) ? m_cnt + 1 : 3;
                    end
                end else if (k != m_pos) begin
                    m_pos = k; serr = 1;
                end
            end
            m_err = serr ? 1'b1 : (clr ? 1'b0 : m_err);
        end
        #1;
    endtask

    task automatic test_reset();
        cycle(0, 0, '0, 0, 0, 0);
        cycle(0, 1, 15'h0001, 0, 1, 0);
        vectors++;
        if (obs() !== expv() || obs() !== '0) begin
            miscompares++;
            $display("FAIL reset: got %b want %b", obs(), expv());
        end
    endtask

    task automatic test_walk();
        logic [WIDTH-1:0] s[6] = '{15'h0001, 15'h0008, 15'h0040,
                                   15'h0200, 15'h1000, 15'h0001};
        for (int i = 0; i < 6; i++) begin
            cycle(1, 1, s[i], 0, 0, 0);
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL walk[%0d]: got %b want %b", i, obs(), expv());
            end
        end
        vectors++;
        if (lap_cnt !== 2'd1 || lap_pulse !== 1'b1 || pos_idx !== 3'd0) begin
            miscompares++;
            $display("FAIL walk_lap: got cnt=%0d lap=%b idx=%0d want 1 1 0",
                     lap_cnt, lap_pulse, pos_idx);
        end
    endtask

    task automatic test_stall();
        cycle(1, 1, 15'h0008, 0, 0, 0);
        cycle(1, 1, 15'h0040, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 15'h0040, 0, 0, 0);
            vectors++;
            if (obs() !== expv() || step !== 1'b0 || pos_idx !== 3'd2) begin
                miscompares++;
                $display("FAIL stall[%0d]: got %b want %b", i, obs(), expv());
            end
        end
    endtask

    task automatic test_illegal();
        logic [WIDTH-1:0] s[3] = '{15'h0002, 15'h0048, 15'h0200};
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, s[i], 0, 0, 0);
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL illegal[%0d]: got %b want %b", i, obs(), expv());
            end
        end
        cycle(1, 0, '0, 0, 0, 1);
        vectors++;
        if (obs() !== expv() || err_sticky !== 1'b0) begin
            miscompares++;
            $display("FAIL err_clr: got %b want %b", obs(), expv());
        end
    endtask

    task automatic test_jump();
        logic [WIDTH-1:0] s[4] = '{15'h1000, 15'h0001, 15'h0008, 15'h1000};
        for (int i = 0; i < 4; i++) begin
            cycle(1, 1, s[i], 0, 0, 0);
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL jump[%0d]: got %b want %b", i, obs(), expv());
            end
        end
        cycle(1, 1, 15'h0000, 0, 0, 1);
        vectors++;
        if (obs() !== expv() || err_sticky !== 1'b1) begin
            miscompares++;
            $display("FAIL set_beats_clr: got %b want %b", obs(), expv());
        end
        cycle(1, 0, '0, 0, 0, 1);
    endtask

    task automatic test_press();
        logic [WIDTH-1:0] s[9] = '{15'h0200, 15'h0200, 15'h1000, 15'h0001,
                                   15'h0008, 15'h0040, 15'h0040, 15'h0200,
                                   15'h1000};
        bit b[9] = '{0, 1, 0, 0, 0, 0, 1, 0, 1};
        for (int i = 0; i < 9; i++) begin
            cycle(1, 1, s[i], 3, b[i], 0);
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL press[%0d]: got %b want %b", i, obs(), expv());
            end
        end
        cycle(1, 1, 15'h7fff, 3, 0, 0);
        cycle(1, 0, '0, 0, 1, 0);
        vectors++;
        if (obs() !== expv() || miss !== 1'b1) begin
            miscompares++;
            $display("FAIL press_invalid: got %b want %b", obs(), expv());
        end
        cycle(1, 1, 15'h0001, 0, 0, 0);
        cycle(1, 0, '0, 7, 1, 0);
        vectors++;
        if (obs() !== expv() || miss !== 1'b1) begin
            miscompares++;
            $display("FAIL press_tgt7: got %b want %b", obs(), expv());
        end
    endtask

    task automatic test_laps();
        cycle(0, 0, '0, 0, 0, 0);
        cycle(1, 1, 15'h0001, 0, 0, 0);
        for (int i = 0; i < 25; i++) begin
            cycle(1, 1, slot_vec((i + 1) % 5), 0, 0, 0);
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL laps[%0d]: got %b want %b", i, obs(), expv());
            end
        end
        vectors++;
        if (lap_cnt !== 2'd3 || lap_pulse !== 1'b1) begin
            miscompares++;
            $display("FAIL lap_sat: got cnt=%0d lap=%b want 3 1",
                     lap_cnt, lap_pulse);
        end
        cycle(1, 1, 15'h0008, 0, 0, 0);
        cycle(1, 1, 15'h0040, 0, 1, 0);
        cycle(0, 1, 15'h0200, 2, 1, 0);
        vectors++;
        if (obs() !== '0 || obs() !== expv()) begin
            miscompares++;
            $display("FAIL mid_reset: got %b want %b", obs(), expv());
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] v;
        int sel;
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 99);
            if (sel < 55)      v = slot_vec((m_pos + 1) % 5);
            else if (sel < 70) v = slot_vec(m_pos);
            else if (sel < 85) v = slot_vec($urandom_range(0, 4));
            else               v = WIDTH'($urandom);
            cycle($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0, v,
                  $urandom_range(0, 7), $urandom_range(0, 2) == 0,
                  $urandom_range(0, 7) == 0);
            vectors++;
            if (obs() !== expv()) begin
                miscompares++;
                $display("FAIL random[%0d]: got %b want %b", i, obs(), expv());
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; ring_in = '0;
        tgt_slot = '0; hit_btn = 1'b0; err_clr = 1'b0;
        m_pos = 0; m_cnt = 0; m_valid = 0; m_step = 0;
        m_lap = 0; m_hit = 0; m_miss = 0; m_err = 0;
        test_reset();
        test_walk();
        test_stall();
        test_illegal();
        test_jump();
        test_press();
        test_laps();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
